// File: rtl/maxbw_ddr_frame_ctrl.sv
// DDR capture sequencer: hunts for a sync word, folds a programmed number of beats into an XOR checksum.
// Optional MAXBW_PERF_EN adds a saturating folded-beat counter readable on out_sel=3.
module maxbw_ddr_frame_ctrl #(
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter int          LEN_W     = 8,
    parameter int          TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [15:0]      din_lo,
    input  logic [15:0]      din_hi,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [1:0]       out_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       csum,
    output logic [7:0]       out_data
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        CAPTURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [TMR_W-1:0] hunt_tmr;
    logic [7:0]       csum_q;
    logic             err_q;
    logic             arm, fold_en, hunt_miss, tmo;
    logic [7:0]       perf_byte;
    logic [7:0]       cnt8;
    logic [LEN_W+7:0] cnt_ext;

    function automatic logic [7:0] fold16(input logic [15:0] x);
        return x[15:8] ^ x[7:0];
    endfunction

    function automatic logic [7:0] beat_fold(input logic [15:0] lo, input logic [15:0] hi);
        return fold16(lo) ^ fold16(hi);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        fold_en   = 1'b0;
        hunt_miss = 1'b0;
        tmo       = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        arm       = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                HUNT: begin
                    // The sync beat itself is a marker only and is never folded.
                    if (din_hi == SYNC_WORD) begin
                        state_nxt = (len_q == '0) ? REPORT : CAPTURE;
                    end else if (hunt_tmr == TMR_W'(TIMEOUT - 1)) begin
                        tmo       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        hunt_miss = 1'b1;
                    end
                end
                CAPTURE: begin
                    fold_en = 1'b1;
                    if (beat_cnt == len_q - LEN_W'(1)) state_nxt = REPORT;
                end
                REPORT: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            beat_cnt <= '0;
            hunt_tmr <= '0;
            csum_q   <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            if (arm) begin
                len_q    <= frame_len;
                beat_cnt <= '0;
                hunt_tmr <= '0;
                csum_q   <= 8'h00;
                err_q    <= 1'b0;
            end
            if (hunt_miss) hunt_tmr <= hunt_tmr + TMR_W'(1);
            if (tmo)       err_q    <= 1'b1;
            if (fold_en) begin
                csum_q   <= csum_q ^ beat_fold(din_lo, din_hi);
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
        end
    end

`ifdef MAXBW_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst)                                  perf_cnt <= 16'h0000;
        else if (fold_en && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
    end

    assign perf_byte = perf_cnt[7:0];
`else
    assign perf_byte = 8'h00;
`endif

    assign busy    = (state != IDLE);
    assign done    = (state == REPORT);
    assign err     = err_q;
    assign csum    = csum_q;
    assign cnt_ext = {8'h00, beat_cnt};
    assign cnt8    = cnt_ext[7:0];

    // Status byte register: one cycle behind out_sel and the sources it selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= 8'h00;
        end else begin
            case (out_sel)
                2'd0:    out_data <= csum_q;
                2'd1:    out_data <= cnt8;
                2'd2:    out_data <= {busy, done, err_q, state, 3'b000};
                default: out_data <= perf_byte;
            endcase
        end
    end

endmodule

// File: tb/tb_maxbw_ddr_frame_ctrl.sv
// Directed bench for maxbw_ddr_frame_ctrl: reset, normal frame, timeout, stall, abort, zero length, perf byte.
module tb_maxbw_ddr_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [15:0] din_lo;
    logic [15:0] din_hi;
    logic [7:0]  frame_len;
    logic [1:0]  out_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  csum;
    logic [7:0]  out_data;

    int checks;
    int errors;

    maxbw_ddr_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .din_lo    (din_lo),
        .din_hi    (din_hi),
        .frame_len (frame_len),
        .out_sel   (out_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .csum      (csum),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] perf_exp;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        en        = 1'b1;
        start     = 1'b0;
        din_lo    = 16'h0000;
        din_hi    = 16'h0000;
        frame_len = 8'd0;
        out_sel   = 2'd0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_csum", csum, 8'h00);
        check("rst_out0", out_data, 8'h00);
        out_sel = 2'd1; tick(); check("rst_out1", out_data, 8'h00);
        out_sel = 2'd2; tick(); check("rst_out2", out_data, 8'h00);
        out_sel = 2'd3; tick(); check("rst_out3", out_data, 8'h00);

        // Normal frame, len=2
        out_sel = 2'd2; start = 1'b1; frame_len = 8'd2; din_hi = 16'h1234;
        tick();
        start = 1'b0;
        check("n_busy_hunt", busy, 1);
        tick(); tick(); tick();
        check("n_out_hunt", out_data, 8'h88);
        din_hi = 16'hA55A;
        tick();
        check("n_sync_done", done, 0);
        din_lo = 16'h0102; din_hi = 16'h0304;
        tick();
        check("n_b1_csum", csum, 8'h04);
        check("n_b1_done", done, 0);
        check("n_out_cap", out_data, 8'h90);
        din_lo = 16'h1010; din_hi = 16'h2020;
        tick();
        check("n_done", done, 1);
        check("n_csum", csum, 8'h04);
        din_lo = 16'h0000; din_hi = 16'h0000;
        tick();
        check("n_done_w", done, 0);
        check("n_busy_end", busy, 0);
        check("n_out_rep", out_data, 8'hD8);
        out_sel = 2'd1; tick(); check("n_out_cnt", out_data, 8'h02);
        out_sel = 2'd0; tick(); check("n_out_csum", out_data, 8'h04);

        // Timeout after 255 unmatched HUNT cycles
        start = 1'b1; frame_len = 8'd2;
        tick();
        start = 1'b0;
        repeat (254) tick();
        check("t_busy_254", busy, 1);
        check("t_err_254", err, 0);
        tick();
        check("t_busy_255", busy, 0);
        check("t_err_255", err, 1);
        check("t_done", done, 0);

        // Next start clears err; zero-length frame
        start = 1'b1; frame_len = 8'd0;
        tick();
        start = 1'b0;
        check("z_err_clr", err, 0);
        check("z_busy", busy, 1);
        din_hi = 16'hA55A;
        tick();
        check("z_done", done, 1);
        check("z_csum", csum, 8'h00);
        din_hi = 16'h0000;
        tick();
        check("z_done_w", done, 0);
        check("z_busy_end", busy, 0);

        // Stall mid-CAPTURE
        start = 1'b1; frame_len = 8'd2; din_hi = 16'h1234;
        tick();
        start = 1'b0; din_hi = 16'hA55A;
        tick();
        din_lo = 16'h0102; din_hi = 16'h0304;
        tick();
        out_sel = 2'd1; en = 1'b0; din_lo = 16'hFFFF; din_hi = 16'h00FF;
        tick(); tick(); tick();
        check("s_cnt_frozen", out_data, 8'h01);
        check("s_csum", csum, 8'h04);
        check("s_done", done, 0);
        check("s_busy", busy, 1);
        en = 1'b1; din_lo = 16'h1010; din_hi = 16'h2020;
        tick();
        check("s_done_late", done, 1);
        check("s_csum_end", csum, 8'h04);
        en = 1'b0;
        tick();
        check("s_done_held", done, 1);
        en = 1'b1;
        tick();
        check("s_done_w", done, 0);
        check("s_busy_end", busy, 0);

        // start during CAPTURE is ignored
        start = 1'b1; frame_len = 8'd3; din_hi = 16'h1234;
        tick();
        start = 1'b0; din_hi = 16'hA55A;
        tick();
        din_lo = 16'h0102; din_hi = 16'h0304;
        tick();
        start = 1'b1; frame_len = 8'd1; din_lo = 16'h1010; din_hi = 16'h2020;
        tick();
        start = 1'b0;
        check("i_busy", busy, 1);
        check("i_done", done, 0);
        check("i_err", err, 0);
        din_lo = 16'h0000; din_hi = 16'h0000;
        tick();
        check("i_done3", done, 1);
        check("i_csum", csum, 8'h04);
        tick();
        check("i_busy_end", busy, 0);

        // rst mid-CAPTURE
        start = 1'b1; frame_len = 8'd3;
        tick();
        start = 1'b0; din_hi = 16'hA55A;
        tick();
        din_lo = 16'h0102; din_hi = 16'h0304;
        tick();
        check("r_csum_pre", csum, 8'h04);
        rst = 1'b1;
        tick();
        rst = 1'b0; din_lo = 16'h0000; din_hi = 16'h0000;
        check("r_busy", busy, 0);
        check("r_csum", csum, 8'h00);
        check("r_done", done, 0);
        tick();
        check("r_done_next", done, 0);
        check("r_busy_next", busy, 0);

        // Two len=2 frames, then perf byte
        out_sel = 2'd3;
        for (int f = 0; f < 2; f++) begin
            start = 1'b1; frame_len = 8'd2;
            tick();
            start = 1'b0; din_hi = 16'hA55A;
            tick();
            din_lo = 16'h0102; din_hi = 16'h0304;
            tick();
            din_lo = 16'h1010; din_hi = 16'h2020;
            tick();
            check("p_done", done, 1);
            check("p_csum", csum, 8'h04);
            din_lo = 16'h0000; din_hi = 16'h0000;
            tick();
        end
        tick();
`ifdef MAXBW_PERF_EN
        perf_exp = 8'h04;
`else
        perf_exp = 8'h00;
`endif
        check("p_perf", out_data, perf_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
